apb_master_bridge_n: RTL and testbench
======================================

Name: apb_master_bridge_n

Overview:
- Parametrised next-generation APB master bridge driving NUM_SLAVES completers over one shared APB bus.
- Configurable address and data width; slave select decoded from the top address bits.
- Adds three things the two-slave bridge lacks: back-to-back transfers without a return to IDLE, per-slave PSLVERR forwarding, and a wait-state timeout that terminates hung transfers with an error.
- Sits between the local request interface (transfer/READ_WRITE/address/data) and the slave array in the APB top level.

Parameters:
- ADDR_W, 9: PADDR width; the low ADDR_W-SEL_W bits go to the slaves.
- DATA_W, 8: PWDATA/PRDATA width.
- NUM_SLAVES, 2: number of completers, minimum 2.
- TIMEOUT, 16: maximum ACCESS cycles with PREADY low before forced error termination; 0 disables the timeout.
- SEL_W, derived = clog2(NUM_SLAVES): number of decode bits.

Ports:
- PCLK  in  1  APB clock; all logic on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- transfer  in  1  request a transfer; sampled in IDLE and on the completing ACCESS cycle.
- READ_WRITE  in  1  1 = read, 0 = write.
- apb_write_paddr  in  ADDR_W  write address.
- apb_write_data  in  DATA_W  write data.
- apb_read_paddr  in  ADDR_W  read address.
- PRDATA  in  NUM_SLAVES*DATA_W  concatenated slave read data; slave n occupies [n*DATA_W +: DATA_W].
- PREADY_s  in  NUM_SLAVES  per-slave PREADY.
- PSLVERR_s  in  NUM_SLAVES  per-slave PSLVERR.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PENABLE  out  1  APB enable.
- PADDR  out  ADDR_W  registered address.
- PWRITE  out  1  registered direction; 1 = write.
- PWDATA  out  DATA_W  registered write data.
- apb_read_data_out  out  DATA_W  last successful read data.
- PSLVERR  out  1  one-cycle error flag, coincident with done.
- done  out  1  one-cycle pulse when a transfer completes.
- busy  out  1  high in SETUP or ACCESS.

Behaviour:
- Reset (asynchronous, any time, including mid-transfer):
  - state goes to IDLE.
  - PSEL, PENABLE, PADDR, PWRITE, PWDATA, apb_read_data_out, PSLVERR, done and busy all go to 0.
  - The timeout counter goes to 0.
- States: IDLE, SETUP, ACCESS.
- IDLE:
  - PSEL=0, PENABLE=0.
  - If transfer=1, capture the request and go to SETUP.
- Capture on entry to SETUP:
  - PADDR = READ_WRITE ? apb_read_paddr : apb_write_paddr.
  - PWRITE = ~READ_WRITE.
  - PWDATA = apb_write_data on writes; held on reads.
- Decode:
  - idx = PADDR[ADDR_W-1 -: SEL_W].
  - If idx < NUM_SLAVES, PSEL[idx]=1 in SETUP and ACCESS.
  - Otherwise PSEL stays all-zero (unmapped).
- SETUP:
  - PENABLE=0; lasts exactly one cycle; next state is always ACCESS.
  - Timeout counter cleared.
- ACCESS:
  - PENABLE=1.
  - Selected-slave ready: rdy = PREADY_s[idx]; err = PSLVERR_s[idx].
  - Unmapped idx: complete on the first ACCESS cycle with error.
  - If rdy=0: counter increments. When TIMEOUT != 0 and counter == TIMEOUT-1 with rdy still 0, the transfer completes with error (TIMEOUT ACCESS cycles total).
- On completion:
  - done=1 and PSLVERR=err for one cycle (forced 1 for timeout or unmapped).
  - Read and no error: apb_read_data_out = selected PRDATA slice.
  - Read with error, or any write: apb_read_data_out holds its value.
  - If transfer=1 on the completing cycle, capture the new request and go directly to SETUP. PSEL is deasserted for that one SETUP cycle only if the target slave changes; PENABLE is 0 in SETUP.
  - Otherwise go to IDLE; PSEL and PENABLE drop to 0.
- Inputs other than transfer are ignored outside the capture points. transfer deasserting mid-transfer has no effect.
- busy = (state != IDLE).
- Minimum transfer is 2 cycles: SETUP plus one ACCESS. Each wait state adds one cycle.

Test Plan:
- Write, zero wait, defaults: transfer=1, READ_WRITE=0, write_paddr=9'h105, data=8'hA5, PREADY_s=2'b11 -> PSEL=2'b10 for 2 cycles; PENABLE only in cycle 2; PWDATA=8'hA5; done pulses in cycle 2; PSLVERR=0.
- Read with 3 wait states: read_paddr=9'h010, slave0 PREADY low 3 cycles, PRDATA slice0=8'h3C -> ACCESS lasts 4 cycles; apb_read_data_out=8'h3C after done.
- Back-to-back: transfer held high for a write to 9'h105 then a read from 9'h0FF -> SETUP follows ACCESS with no IDLE cycle; PSEL goes 10 -> 01.
- Timeout: TIMEOUT=4, PREADY_s=0 -> done and PSLVERR=1 on the 4th ACCESS cycle; apb_read_data_out unchanged; state returns to IDLE.
- Unmapped and slave error: NUM_SLAVES=3, addr 9'h1C0 -> PSEL=0, error on the first ACCESS cycle. Slave1 with PSLVERR_s[1]=1 on a read -> PSLVERR=1 and read data not updated.
- Reset mid-ACCESS: PRESETn low during a wait state -> all outputs 0 immediately (asynchronous); after release, a new transfer completes normally.

Source files
------------

// File: rtl/apb_master_bridge_n.sv
`default_nettype none
// ============================================================================
// Module  : apb_master_bridge_n
// Brief   : APB master bridge for NUM_SLAVES completers on one shared bus.
//           Supports back-to-back transfers without an IDLE cycle, forwards
//           the selected slave's PSLVERR, and ends hung transfers with an
//           error after TIMEOUT wait cycles.
// Revision: 1.0 - initial release
// ============================================================================
module apb_master_bridge_n #(
  parameter int ADDR_W     = 9,
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  input  logic                         transfer,
  input  logic                         READ_WRITE,
  input  logic [ADDR_W-1:0]            apb_write_paddr,
  input  logic [DATA_W-1:0]            apb_write_data,
  input  logic [ADDR_W-1:0]            apb_read_paddr,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PREADY_s,
  input  logic [NUM_SLAVES-1:0]        PSLVERR_s,
  output logic [NUM_SLAVES-1:0]        PSEL,
  output logic                         PENABLE,
  output logic [ADDR_W-1:0]            PADDR,
  output logic                         PWRITE,
  output logic [DATA_W-1:0]            PWDATA,
  output logic [DATA_W-1:0]            apb_read_data_out,
  output logic                         PSLVERR,
  output logic                         done,
  output logic                         busy
);

  localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  // The counter only has to reach TIMEOUT-1; the transfer ends there.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic                pwrite_q, pwrite_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  // Set when a back-to-back request targets a different slave: PSEL is
  // withheld for that SETUP cycle so two selects never overlap.
  logic                hide_q, hide_d;

  logic [SEL_W-1:0]    w_idx;
  logic [SEL_W-1:0]    w_new_idx;
  logic [ADDR_W-1:0]   w_new_addr;
  logic [NUM_SLAVES-1:0] w_onehot;
  logic                w_mapped;
  logic                w_rdy;
  logic                w_err;
  logic [DATA_W-1:0]   w_rdata_sel;
  logic                w_timeout;
  logic                w_complete;
  logic                w_xfer_err;
  logic                w_capture;
  logic [DATA_W-1:0]   w_slice [NUM_SLAVES];

  // Split the concatenated read-data bus into one lane per slave.
  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slice
    assign w_slice[g] = PRDATA[g*DATA_W +: DATA_W];
  end

  assign w_idx      = paddr_q[ADDR_W-1 -: SEL_W];
  assign w_new_addr = READ_WRITE ? apb_read_paddr : apb_write_paddr;
  assign w_new_idx  = w_new_addr[ADDR_W-1 -: SEL_W];

  // Decode the registered address; an index beyond NUM_SLAVES matches no lane.
  always_comb begin
    w_onehot    = '0;
    w_rdy       = 1'b0;
    w_err       = 1'b0;
    w_rdata_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (w_idx == SEL_W'(i)) begin
        w_onehot[i] = 1'b1;
        w_rdy       = PREADY_s[i];
        w_err       = PSLVERR_s[i];
        w_rdata_sel = w_slice[i];
      end
    end
  end

  assign w_mapped   = |w_onehot;
  assign w_timeout  = (TIMEOUT != 0) && !w_rdy && (cnt_q == CNT_LAST);
  assign w_complete = (state_q == S_ACCESS) && (!w_mapped || w_rdy || w_timeout);
  // Unmapped, timed out (not ready at completion) or slave-reported error.
  assign w_xfer_err = !w_mapped || !w_rdy || w_err;

  // Next-state logic, request capture and completion bookkeeping.
  always_comb begin
    state_d   = state_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    hide_d    = hide_q;
    w_capture = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (transfer) begin
          w_capture = 1'b1;
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (w_complete) begin
          if (!pwrite_q && !w_xfer_err) begin
            rdata_d = w_rdata_sel;
          end
          if (transfer) begin
            w_capture = 1'b1;
            state_d   = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (w_capture) begin
      paddr_d  = w_new_addr;
      pwrite_d = ~READ_WRITE;
      if (!READ_WRITE) begin
        pwdata_d = apb_write_data;
      end
      hide_d = (state_q == S_ACCESS) && (w_new_idx != w_idx);
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= S_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      hide_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      hide_q   <= hide_d;
    end
  end

  assign busy              = (state_q != S_IDLE);
  assign PENABLE           = (state_q == S_ACCESS);
  assign PSEL              = (busy && !((state_q == S_SETUP) && hide_q)) ? w_onehot : '0;
  assign done              = w_complete;
  assign PSLVERR           = w_complete && w_xfer_err;
  assign PADDR             = paddr_q;
  assign PWRITE            = pwrite_q;
  assign PWDATA            = pwdata_q;
  assign apb_read_data_out = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge_n.sv
`default_nettype none
// ============================================================================
// Module  : tb_apb_master_bridge_n
// Brief   : Randomized bench for apb_master_bridge_n against a transaction
//           level reference model (3 slaves, TIMEOUT 5).
// Revision: 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge_n;

  localparam int AW = 9;
  localparam int DW = 8;
  localparam int NS = 3;
  localparam int TO = 5;
  localparam int SW = $clog2(NS);

  logic              PCLK = 1'b0;
  logic              PRESETn = 1'b0;
  logic              transfer;
  logic              READ_WRITE;
  logic [AW-1:0]     apb_write_paddr;
  logic [DW-1:0]     apb_write_data;
  logic [AW-1:0]     apb_read_paddr;
  logic [NS*DW-1:0]  PRDATA;
  logic [NS-1:0]     PREADY_s;
  logic [NS-1:0]     PSLVERR_s;
  logic [NS-1:0]     PSEL;
  logic              PENABLE;
  logic [AW-1:0]     PADDR;
  logic              PWRITE;
  logic [DW-1:0]     PWDATA;
  logic [DW-1:0]     apb_read_data_out;
  logic              PSLVERR;
  logic              done;
  logic              busy;

  always #5 PCLK = ~PCLK;

  apb_master_bridge_n #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .NUM_SLAVES (NS),
    .TIMEOUT    (TO)
  ) dut (
    .PCLK              (PCLK),
    .PRESETn           (PRESETn),
    .transfer          (transfer),
    .READ_WRITE        (READ_WRITE),
    .apb_write_paddr   (apb_write_paddr),
    .apb_write_data    (apb_write_data),
    .apb_read_paddr    (apb_read_paddr),
    .PRDATA            (PRDATA),
    .PREADY_s          (PREADY_s),
    .PSLVERR_s         (PSLVERR_s),
    .PSEL              (PSEL),
    .PENABLE           (PENABLE),
    .PADDR             (PADDR),
    .PWRITE            (PWRITE),
    .PWDATA            (PWDATA),
    .apb_read_data_out (apb_read_data_out),
    .PSLVERR           (PSLVERR),
    .done              (done),
    .busy              (busy)
  );

  // One planned transaction: request plus how the target slave responds.
  typedef struct {
    bit            rw;     // 1 = read
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            w;      // wait states before the slave is ready
    bit            e;      // slave reports an error
    logic [DW-1:0] d;      // slave read data
    bit            b2b;    // next request follows on the completing cycle
  } txn_t;

  txn_t dq[$];
  txn_t cur;
  txn_t nxt;
  bit   have_pending;

  // Reference model of the bridge's externally visible registers.
  logic [AW-1:0] m_paddr;
  bit            m_pwrite;
  logic [DW-1:0] m_pwdata;
  logic [DW-1:0] m_rdata;
  int            m_prev_idx;

  int n_vec;
  int n_err;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_cycle(input logic [NS-1:0] psel, input bit pen, input bit bsy,
                             input bit dn, input bit err);
    check_val("PSEL",    32'(PSEL),    32'(psel));
    check_val("PENABLE", 32'(PENABLE), 32'(pen));
    check_val("busy",    32'(busy),    32'(bsy));
    check_val("done",    32'(done),    32'(dn));
    check_val("PSLVERR", 32'(PSLVERR), 32'(err));
    check_val("PADDR",   32'(PADDR),   32'(m_paddr));
    check_val("PWRITE",  32'(PWRITE),  32'(m_pwrite));
    check_val("PWDATA",  32'(PWDATA),  32'(m_pwdata));
    check_val("RDATA",   32'(apb_read_data_out), 32'(m_rdata));
  endtask

  function automatic int idx_of(input logic [AW-1:0] a);
    return int'(a >> (AW - SW));
  endfunction

  function automatic logic [NS-1:0] onehot(input int i);
    logic [NS-1:0] v;
    v = '0;
    if (i < NS) v[i] = 1'b1;
    return v;
  endfunction

  task automatic drive_noise();
    PREADY_s  = NS'($urandom);
    PSLVERR_s = NS'($urandom);
    PRDATA    = (NS*DW)'($urandom);
  endtask

  task automatic drive_junk_req(input bit tr);
    transfer        = tr;
    READ_WRITE      = 1'($urandom);
    apb_write_paddr = AW'($urandom);
    apb_read_paddr  = AW'($urandom);
    apb_write_data  = DW'($urandom);
  endtask

  task automatic drive_req(input txn_t t);
    drive_junk_req(1'b1);
    READ_WRITE     = t.rw;
    apb_write_data = t.wd;
    if (t.rw) apb_read_paddr  = t.addr;
    else      apb_write_paddr = t.addr;
  endtask

  function automatic txn_t get_txn();
    txn_t t;
    if (dq.size() != 0) return dq.pop_front();
    t.rw   = 1'($urandom);
    t.addr = AW'($urandom);
    t.wd   = DW'($urandom);
    t.w    = int'($urandom_range(0, 7));
    t.e    = ($urandom % 5) == 0;
    t.d    = DW'($urandom);
    t.b2b  = 1'($urandom);
    return t;
  endfunction

  // Runs SETUP and ACCESS of cur; the request was captured on the prior edge.
  task automatic run_body(input bit from_b2b);
    int            idx;
    bit            mapped;
    bit            hide;
    bit            to_hit;
    bit            xerr;
    int            jend;
    logic [NS-1:0] oh;
    idx    = idx_of(cur.addr);
    mapped = idx < NS;
    oh     = onehot(idx);
    hide   = from_b2b && (idx != m_prev_idx);
    to_hit = mapped && (TO != 0) && (cur.w >= TO);
    jend   = !mapped ? 0 : (to_hit ? TO - 1 : cur.w);
    xerr   = !mapped || to_hit || cur.e;
    m_paddr  = cur.addr;
    m_pwrite = !cur.rw;
    if (!cur.rw) m_pwdata = cur.wd;

    @(negedge PCLK);
    drive_noise();
    drive_junk_req(1'($urandom));
    #1;
    check_cycle(hide ? '0 : oh, 1'b0, 1'b1, 1'b0, 1'b0);

    for (int j = 0; j <= jend; j++) begin
      @(negedge PCLK);
      drive_noise();
      if (mapped) begin
        PREADY_s[idx]            = (j >= cur.w);
        PSLVERR_s[idx]           = cur.e;
        PRDATA[idx*DW +: DW]     = cur.d;
      end
      if (j == jend) begin
        if (cur.b2b) begin
          nxt = get_txn();
          drive_req(nxt);
        end else begin
          drive_junk_req(1'b0);
        end
      end else begin
        drive_junk_req(1'($urandom));
      end
      #1;
      check_cycle(oh, 1'b1, 1'b1, j == jend, (j == jend) && xerr);
    end

    if (cur.rw && !xerr) m_rdata = cur.d;
    m_prev_idx   = idx;
    have_pending = cur.b2b;
  endtask

  task automatic run_txns(input int n);
    for (int t = 0; t < n; t++) begin
      if (!have_pending) begin
        cur = get_txn();
        if (t == n - 1) cur.b2b = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(negedge PCLK);
          drive_noise();
          drive_junk_req(1'b0);
          #1;
          check_cycle('0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge PCLK);
        drive_noise();
        drive_req(cur);
        #1;
        check_cycle('0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_body(1'b0);
      end else begin
        cur = nxt;
        if (t == n - 1) cur.b2b = 1'b0;
        run_body(1'b1);
      end
    end
  endtask

  function automatic txn_t mk(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input int w, input bit e, input logic [DW-1:0] d, input bit b2b);
    txn_t t;
    t.rw = rw; t.addr = a; t.wd = wd; t.w = w; t.e = e; t.d = d; t.b2b = b2b;
    return t;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0; m_rdata = '0; m_prev_idx = 0;
    have_pending = 1'b0;
    drive_noise();
    drive_junk_req(1'b0);

    // Reset state
    repeat (2) @(negedge PCLK);
    #1;
    check_cycle('0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge PCLK);
    PRESETn = 1'b1;

    // Directed cases first, then random traffic.
    dq.push_back(mk(1'b0, 9'h105, 8'hA5, 0, 1'b0, 8'h00, 1'b0)); // write, zero wait
    dq.push_back(mk(1'b1, 9'h010, 8'h00, 3, 1'b0, 8'h3C, 1'b0)); // read, 3 waits
    dq.push_back(mk(1'b0, 9'h105, 8'h5A, 0, 1'b0, 8'h00, 1'b1)); // b2b, slave change
    dq.push_back(mk(1'b1, 9'h0FF, 8'h00, 1, 1'b0, 8'h77, 1'b0));
    dq.push_back(mk(1'b1, 9'h040, 8'h00, 7, 1'b0, 8'h99, 1'b0)); // timeout
    dq.push_back(mk(1'b1, 9'h1C0, 8'h00, 0, 1'b0, 8'h55, 1'b0)); // unmapped
    dq.push_back(mk(1'b1, 9'h080, 8'h00, 0, 1'b1, 8'h11, 1'b0)); // slave error
    dq.push_back(mk(1'b1, 9'h010, 8'h00, 0, 1'b0, 8'h21, 1'b1)); // b2b, same slave
    dq.push_back(mk(1'b0, 9'h020, 8'hC3, 2, 1'b0, 8'h00, 1'b0));
    dq.push_back(mk(1'b1, 9'h030, 8'h00, 4, 1'b0, 8'h6E, 1'b0)); // ready on last count
    run_txns(80);

    // Asynchronous reset in the middle of a wait state
    @(negedge PCLK);
    drive_noise();
    PREADY_s = '0;
    drive_junk_req(1'b1);
    READ_WRITE     = 1'b1;
    apb_read_paddr = 9'h010;
    #1;
    check_cycle('0, 1'b0, 1'b0, 1'b0, 1'b0);
    m_paddr  = 9'h010;
    m_pwrite = 1'b0;
    @(negedge PCLK);
    PREADY_s = '0;
    transfer = 1'b0;
    #1;
    check_cycle(onehot(0), 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge PCLK);
    PREADY_s = '0;
    #1;
    check_cycle(onehot(0), 1'b1, 1'b1, 1'b0, 1'b0);
    #2;
    PRESETn = 1'b0;
    #1;
    m_paddr = '0; m_pwrite = 1'b0; m_pwdata = '0; m_rdata = '0;
    check_cycle('0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge PCLK);
    PRESETn = 1'b1;
    have_pending = 1'b0;
    dq.push_back(mk(1'b1, 9'h090, 8'h00, 1, 1'b0, 8'hE7, 1'b0));
    run_txns(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
